// File: rtl/instruction_fetch.sv
// Instruction fetch front end: credit-limited word fetches, in-order response FIFO, redirect flush.
// Optional IFETCH_MISALIGN_CHECK_EN adds o_misaligned and halts fetch after a misaligned redirect.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic        o_misaligned
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = 4;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          run_q;
  logic [31:0]   mem_pc_q  [DEPTH];
  logic [31:0]   mem_ins_q [DEPTH];

  logic          fire, rsp_drop, rsp_take, push, pop, fetch_halt;
  logic [4:0]    credit_used;
  logic [31:0]   redirect_target;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign redirect_target = i_redirect_pc & 32'hFFFF_FFFC;
  // Every word buffered, in flight or awaiting discard holds one credit.
  assign credit_used = 5'(count_q) + 5'(inflight_q) + 5'(discard_q);

  assign o_imem_req  = run_q && (credit_used < 5'(DEPTH)) && !i_redirect && !fetch_halt;
  assign o_imem_addr = fetch_pc_q;
  assign fire        = o_imem_req && i_imem_gnt;
  assign rsp_drop    = i_imem_rvalid && (discard_q != '0);
  assign rsp_take    = i_imem_rvalid && (discard_q == '0) && (inflight_q != '0);
  assign push        = rsp_take && !i_redirect;
  assign pop         = o_valid && i_ready;

  assign o_valid       = (count_q != '0);
  assign o_pc          = o_valid ? mem_pc_q[rd_ptr_q]  : '0;
  assign o_instruction = o_valid ? mem_ins_q[rd_ptr_q] : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (i_redirect) begin
      // Everything still outstanding after this edge becomes stale.
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = '0;
      discard_d  = discard_q + inflight_q + CW'(fire) - CW'(rsp_drop | rsp_take);
    end else begin
      inflight_d = inflight_q + CW'(fire) - CW'(rsp_take);
      discard_d  = discard_q - CW'(rsp_drop);
      if (push) begin
        wr_ptr_d  = ptr_inc(wr_ptr_q);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      run_q      <= 1'b1;
    end
  end

  // Storage needs no reset: outputs are gated by o_valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]  <= resp_pc_q;
      mem_ins_q[wr_ptr_q] <= i_imem_rdata;
    end
  end

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic halt_q, mis_q;
  assign fetch_halt   = halt_q;
  assign o_misaligned = mis_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      halt_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      mis_q <= i_redirect && (i_redirect_pc[1:0] != 2'b00);
      if (i_redirect) halt_q <= (i_redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign fetch_halt = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: imem responder, decode sink and redirect driver,
// with a queue-based reference model and scoreboard.
module tb_instruction_fetch;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        o_misaligned;
`endif

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_instruction(o_instruction),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
`ifdef IFETCH_MISALIGN_CHECK_EN
    , .o_misaligned(o_misaligned)
`endif
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  int pops  = 0;

  // stimulus knobs (percent) and one-shot redirect request
  int          gnt_pct = 100, rv_pct = 100, ready_pct = 100, redir_pct = 0;
  bit          redir_req = 0;
  logic [31:0] redir_target = '0;

  // reference model state
  logic [64:0] exp_q[$];   // {arrived, pc, instruction} for live fetches not yet consumed
  logic [32:0] rsp_q[$];   // {stale, addr} for granted requests whose response is pending
  logic [31:0] model_pc;
  bit          oor = 0;
  bit          halted = 0;
  bit          prev_redirect = 0;
  bit          prev_misaligned = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'hff010113;
    return (addr * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (rsp_q[i]) if (rsp_q[i][32]) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: imem responder, decode sink and redirect source
  initial begin
    i_imem_gnt = 0; i_imem_rvalid = 0; i_imem_rdata = '0;
    i_ready = 0; i_redirect = 0; i_redirect_pc = '0;
    forever begin
      @(negedge i_clk);
      i_redirect = 1'b0;
      if (redir_req) begin
        i_redirect = 1'b1; i_redirect_pc = redir_target; redir_req = 0;
      end else if (i_rst_n && $urandom_range(0, 99) < redir_pct) begin
        i_redirect = 1'b1;
        i_redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom();
      end
      i_imem_gnt = ($urandom_range(0, 99) < gnt_pct);
      i_ready    = ($urandom_range(0, 99) < ready_pct);
      if (rsp_q.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = mem_word(rsp_q[0][31:0]);
      end else begin
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = $urandom();
      end
    end
  end

  // monitor / scoreboard: compare first, then advance the model by this cycle's events
  initial begin
    logic        exp_req, exp_valid, fire;
    logic [32:0] r;
    forever begin
      @(negedge i_clk); #3;
      if (!i_rst_n) begin
        chk("reset_req", 64'(o_imem_req), 64'd0);
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_pc", 64'(o_pc), 64'd0);
        chk("reset_ins", 64'(o_instruction), 64'd0);
        exp_q.delete(); rsp_q.delete();
        model_pc = RESET_PC; oor = 0; halted = 0; prev_redirect = 0; prev_misaligned = 0;
      end else begin
        exp_req   = oor && (exp_q.size() + stale_cnt() < DEPTH) && !i_redirect && !halted;
        exp_valid = (exp_q.size() > 0) && exp_q[0][64];
        chk("req", 64'(o_imem_req), 64'(exp_req));
        if (exp_req) chk("addr", 64'(o_imem_addr), 64'(model_pc));
        chk("valid", 64'(o_valid), 64'(exp_valid));
        if (exp_valid && o_valid) chk("head", {o_pc, o_instruction}, exp_q[0][63:0]);
        if (prev_redirect) chk("valid_after_redirect", 64'(o_valid), 64'd0);
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk("misaligned", 64'(o_misaligned), 64'(prev_misaligned));
`endif
        fire = exp_req && i_imem_gnt;
        if (exp_valid && i_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
        if (i_imem_rvalid && rsp_q.size() > 0) begin
          r = rsp_q.pop_front();
          if (!r[32] && !i_redirect) begin
            for (int i = 0; i < exp_q.size(); i++)
              if (!exp_q[i][64]) begin
                exp_q[i] = {1'b1, exp_q[i][63:0]};
                break;
              end
          end
        end
        if (fire) begin
          rsp_q.push_back({1'b0, model_pc});
          exp_q.push_back({1'b0, model_pc, mem_word(model_pc)});
          model_pc = model_pc + 32'd4;
        end
        prev_redirect   = i_redirect;
        prev_misaligned = 0;
        if (i_redirect) begin
          exp_q.delete();
          foreach (rsp_q[i]) rsp_q[i] = {1'b1, rsp_q[i][31:0]};
          model_pc = i_redirect_pc & 32'hFFFF_FFFC;
`ifdef IFETCH_MISALIGN_CHECK_EN
          halted          = (i_redirect_pc[1:0] != 2'b00);
          prev_misaligned = halted;
`endif
        end
        oor = 1;
      end
    end
  end

  task automatic step();
    @(negedge i_clk); #4;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!o_valid && k < 50);
    if (!o_valid) chk("wait_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redir_target = t; redir_req = 1;
    step();   // redirect cycle
  endtask

  // main sequence
  initial begin
    int k, p0;
    i_rst_n = 0;
    repeat (3) step();
    @(negedge i_clk); i_rst_n = 1; #4;
    k = 0;
    while (!o_valid && k < 20) begin
      step();
      k++;
    end
    chk("first_latency", 64'(k), 64'd3);
    chk("first_pc", 64'(o_pc), 64'h0);
    chk("first_ins", 64'(o_instruction), 64'hff010113);
    repeat (6) step();

    // decode stall: FIFO fills and requests stop
    ready_pct = 0;
    repeat (6) step();
    chk("stall_req_low", 64'(o_imem_req), 64'd0);
    chk("stall_valid", 64'(o_valid), 64'd1);
    ready_pct = 100;
    repeat (6) step();

    // grant withheld: address must hold
    gnt_pct = 0;
    repeat (3) step();
    gnt_pct = 100;
    repeat (4) step();

    // redirect with responses in flight
    rv_pct = 0;
    repeat (4) step();
    rv_pct = 100;
    do_redirect(32'h0000_0100);
    wait_valid(k);
    chk("redirect_pc", 64'(o_pc), 64'h100);
    repeat (4) step();

    // redirect on a busy cycle, misaligned target
    do_redirect(32'h0000_0103);
`ifdef IFETCH_MISALIGN_CHECK_EN
    repeat (5) begin
      step();
      chk("halt_req_low", 64'(o_imem_req), 64'd0);
    end
    do_redirect(32'h0000_0200);
    wait_valid(k);
    chk("resume_pc", 64'(o_pc), 64'h200);
`else
    wait_valid(k);
    chk("misalign_pc", 64'(o_pc), 64'h100);
`endif

    // random traffic
    for (int seg = 0; seg < 30; seg++) begin
      gnt_pct   = $urandom_range(20, 100);
      rv_pct    = $urandom_range(20, 100);
      ready_pct = $urandom_range(10, 100);
      redir_pct = $urandom_range(0, 6);
      repeat (100) step();
    end

    // mid-run reset, then confirm forward progress
    @(negedge i_clk); i_rst_n = 0; #4;
    repeat (2) step();
    @(negedge i_clk); i_rst_n = 1; #4;
    gnt_pct = 100; rv_pct = 100; ready_pct = 100; redir_pct = 0;
    redir_req = 1; redir_target = 32'h0000_0040;
    repeat (4) step();
    p0 = pops;
    repeat (40) step();
    chk("progress", 64'(pops - p0 > 20), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front end of the core. Produces the (pc, instruction) pair consumed by instruction_decode.
- Issues word fetches to instruction memory over a request/grant plus in-order response interface.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts jump/branch redirects from execute; redirects flush the buffer and discard stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction FIFO entries; also the cap on in-flight plus buffered words. Legal range 1..8.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- i_imem_gnt  in  1  request accepted this cycle.
- i_imem_rvalid  in  1  response word valid; responses return in request order.
- i_imem_rdata  in  32  response instruction word.
- o_valid  out  1  o_pc / o_instruction valid toward decode.
- i_ready  in  1  decode accepts the word this cycle.
- o_pc  out  32  pc of the presented instruction (drives decode i_pc).
- o_instruction  out  32  presented instruction word (drives decode i_instruction).
- i_redirect  in  1  jump/branch taken; single-cycle pulse.
- i_redirect_pc  in  32  new fetch target.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC; FIFO empty; inflight=0; discard=0.
  - o_valid=0, o_pc=0, o_instruction=0, o_imem_req=0.
- Request logic (combinational):
  - o_imem_req = out_of_reset && (count+inflight+discard < DEPTH) && !i_redirect.
  - o_imem_addr = fetch_pc.
  - While req is high and gnt is low, the address is held stable. The only exception is a redirect, which withdraws the request.
  - On req&&gnt: fetch_pc += 4 (wraps at 2^32), inflight++.
- Response:
  - On rvalid with discard>0: discard--, word dropped.
  - Otherwise: inflight--, push {pc_of_request, rdata}.
  - The pc is tracked in a per-in-flight pc queue or an equivalent incrementing pointer.
  - The pushed word appears on o_valid the cycle after rvalid. There is no bypass.
- Decode handshake:
  - o_valid = FIFO non-empty; outputs show the FIFO head.
  - Dequeue on o_valid&&i_ready.
  - Head is held stable while o_valid&&!i_ready.
  - A simultaneous push and pop is allowed at any occupancy.
  - Overflow is impossible by the credit rule. An rvalid arriving with no inflight and no discard is a protocol error: ignored, no state change.
- Redirect (sampled at clock edge):
  - fetch_pc <= {i_redirect_pc[31:2],2'b00}.
  - FIFO cleared.
  - discard <= discard + inflight, including a request granted in the same cycle and excluding an rvalid consumed in the same cycle.
  - inflight <= 0.
  - Any rvalid in the redirect cycle is dropped.
  - A pop in the redirect cycle is still honoured.
  - o_valid=0 the cycle after redirect.
- Fetch latency: first request in the first cycle after reset deassertion. With gnt=1 and rvalid one cycle later, o_valid rises three cycles after reset release.
- Reset mid-operation clears all counters; responses arriving after reset are ignored per the protocol-error rule.

Optional Feature:
- Macro: IFETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output o_misaligned (1 bit, reset 0).
  - A redirect with i_redirect_pc[1:0]!=0 pulses o_misaligned for one cycle and performs the flush.
  - Fetching then halts (o_imem_req=0) until the next aligned redirect.
- Undefined: no extra port; low bits are silently forced to zero and fetching continues.

Test Plan:
- Reset release, RESET_PC=0, gnt=1, rvalid one cycle after gnt with rdata=32'hff010113 → o_valid with o_pc=0 and o_instruction=ff010113; following words at pc 4, 8.
- i_ready=0 for 5 cycles with DEPTH=2 → at most 2 words buffered, o_imem_req=0, head stable. Releasing ready gives in-order delivery with no loss or duplication.
- gnt held low 3 cycles → o_imem_addr stable at 0x10 throughout; fetch_pc advances only on gnt.
- Redirect to 0x100 with 2 responses in flight → both stale rvalids dropped, FIFO empty next cycle, next o_pc=0x100.
- Redirect in the same cycle as gnt and rvalid → granted word discarded, rvalid word dropped, fetch resumes at the target.
- Redirect to 0x103 → without macro the fetch goes to 0x100; with IFETCH_MISALIGN_CHECK_EN, o_misaligned=1 for one cycle and no requests until a redirect to 0x200.
